// File: rtl/spy_input_pkg.sv
// spy_input_pkg: shared state enum, axis type and centre/idle constants for the analog input block
package spy_input_pkg;
  typedef logic [7:0] axis_t;
  typedef enum logic [2:0] {IDLE, CAPTURE, TARGET, SLEW, COMMIT} state_t;
  localparam axis_t STEER_CENTRE = 8'h70;
  localparam axis_t GAS_IDLE = 8'h01;
endpackage

// File: rtl/slew_limiter.sv
// slew_limiter: moves cur toward tgt by at most up (rising) or dn (falling), landing exactly on tgt
module slew_limiter
  import spy_input_pkg::*;
(
  input  axis_t cur,
  input  axis_t tgt,
  input  axis_t up,
  input  axis_t dn,
  output axis_t nxt
);
  logic signed [8:0] d;
  assign d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
  assign nxt = (d > $signed({1'b0, up})) ? cur + up :
               (d < -$signed({1'b0, dn})) ? cur - dn : tgt;
endmodule

// File: rtl/spy_analog_input.sv
// spy_analog_input: per-frame analog stick to steering/gas conversion with deadzone and slew limiting
module spy_analog_input
  import spy_input_pkg::*;
#(
  parameter int DEADZONE   = 8,
  parameter int STEER_STEP = 4,
  parameter int GAS_UP     = 8,
  parameter int GAS_DN     = 16
) (
  input  logic        clock_40,
  input  logic        reset,
  input  logic        vsync,
  input  logic [15:0] joy_a,
  output logic [7:0]  steering,
  output logic [7:0]  gas,
  output logic        upd,
  output logic        busy
);
  localparam logic signed [8:0] DZ = 9'(DEADZONE);
  localparam axis_t SS = 8'(STEER_STEP);
  localparam axis_t GU = 8'(GAS_UP);
  localparam axis_t GD = 8'(GAS_DN);
  state_t state, state_nx;
  logic vsync_q, pending, tick;
  axis_t x_s, y_s, steer_t, gas_t, steer_r, gas_r, steer_nx, gas_nx, steer_tg, gas_tg;
  logic signed [8:0] xs, ax, ys, ny;
  logic signed [7:0] xh;
  assign tick = vsync & ~vsync_q;
  assign xs = {x_s[7], x_s};
  assign ax = xs[8] ? -xs : xs;
  assign xh = $signed(x_s) >>> 1;
  assign steer_tg = (ax <= DZ) ? STEER_CENTRE : STEER_CENTRE + axis_t'(xh);
  assign ys = {y_s[7], y_s};
  assign ny = -ys;
  assign gas_tg = (ys >= -DZ) ? GAS_IDLE : {(ny > 9'sd127) ? 7'h7f : ny[6:0], 1'b1};
  slew_limiter u_steer (.cur(steer_r), .tgt(steer_t), .up(SS), .dn(SS), .nxt(steer_nx));
  slew_limiter u_gas   (.cur(gas_r),   .tgt(gas_t),   .up(GU), .dn(GD), .nxt(gas_nx));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (tick | pending) ? CAPTURE : IDLE;
      CAPTURE: state_nx = TARGET;
      TARGET:  state_nx = SLEW;
      SLEW:    state_nx = COMMIT;
      default: state_nx = IDLE;
    endcase
  end
  // outputs load on the SLEW->COMMIT edge so new values are valid while upd is high
  always_ff @(posedge clock_40 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      vsync_q <= 1'b0;
      pending <= 1'b0;
      x_s     <= '0;
      y_s     <= '0;
      steer_t <= STEER_CENTRE;
      gas_t   <= GAS_IDLE;
      steer_r <= STEER_CENTRE;
      gas_r   <= GAS_IDLE;
    end else begin
      state   <= state_nx;
      vsync_q <= vsync;
      pending <= (state == IDLE) ? 1'b0 : pending | tick;
      if (state == CAPTURE) {y_s, x_s} <= joy_a;
      if (state == TARGET) begin
        steer_t <= steer_tg;
        gas_t   <= gas_tg;
      end
      if (state == SLEW) begin
        steer_r <= steer_nx;
        gas_r   <= gas_nx;
      end
    end
  end
  assign steering = steer_r;
  assign gas = gas_r | 8'h01;
  assign upd = (state == COMMIT);
  assign busy = (state != IDLE);
endmodule

// File: doc/spy_analog_input.md
SPY_ANALOG_INPUT -- requirements
Module: spy_analog_input

Interface
REQ-001 Parameter DEADZONE, default 8: stick deflection magnitude at or below which an axis reads as centred.
REQ-002 Parameter STEER_STEP, default 4: maximum steering change per frame.
REQ-003 Parameter GAS_UP, default 8: maximum gas increase per frame.
REQ-004 Parameter GAS_DN, default 16: maximum gas decrease per frame.
REQ-005 clock_40  in  1  system clock; the only clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 vsync  in  1  game vertical sync, synchronous to clock_40.
REQ-008 joy_a  in  16  analog stick; [7:0] signed X (steer), [15:8] signed Y (negative = accelerate).
REQ-009 steering  out  8  steering value to game; centre 0x70.
REQ-010 gas  out  8  pedal value to game; bit0 always 1.
REQ-011 upd  out  1  one-cycle pulse when steering/gas are written.
REQ-012 busy  out  1  high while the frame pipeline is not in IDLE.

Function
REQ-013 The block SHALL form tick as a one-cycle pulse on each vsync 0->1 edge, using a registered previous vsync value.
REQ-014 The FSM SHALL have states IDLE, CAPTURE, TARGET, SLEW, COMMIT, each lasting exactly one cycle except IDLE.
- IDLE: on tick or pending go to CAPTURE.
- CAPTURE -> TARGET -> SLEW -> COMMIT -> IDLE.
REQ-015 CAPTURE SHALL latch joy_a into internal sample registers; later joy_a changes SHALL not affect the frame.
REQ-016 TARGET: steer target SHALL be 0x70 if |X| <= DEADZONE, else 0x70 + (X arithmetic-shift-right 1), computed 8-bit.
- Resulting range: 0x30..0xAF.
REQ-017 TARGET: gas target SHALL be 0x01 if Y >= -DEADZONE.
- Otherwise gas target = {min(-Y,127)[6:0],1'b1}.
- Y = -128 clamps to 0xFF.
REQ-018 SLEW, for each axis with d = target - current:
- |d| <= step: next = target.
- Otherwise: next = current ± step toward target.
- Gas uses step GAS_UP when rising and GAS_DN when falling.
- Arithmetic in 9-bit signed; the result never overshoots the target or wraps.
REQ-019 COMMIT SHALL register steering and gas and assert upd for that one cycle.
- Latency: tick to upd = 4 cycles.
REQ-020 A tick arriving while not in IDLE SHALL set pending.
- pending is cleared on entry to CAPTURE.
- Multiple ticks while busy collapse into one pending.
REQ-021 A tick coinciding with COMMIT SHALL set pending; the FSM then goes IDLE -> CAPTURE on the next cycle.
REQ-022 busy SHALL be high in CAPTURE, TARGET, SLEW, COMMIT.
REQ-023 gas bit0 SHALL be 1 in every cycle, including during reset.

Reset
REQ-024 While reset is high, the block SHALL hold:
- state = IDLE, pending = 0, previous vsync = 0.
- steering = 0x70, gas = 0x01, upd = 0, busy = 0.
- sample registers = 0.
REQ-025 Reset asserted mid-pipeline SHALL abandon the frame, with no upd pulse and outputs at reset values.
- Processing resumes on the first vsync edge after release.

Structure
REQ-026 Package spy_input_pkg SHALL hold:
- the FSM state enum;
- STEER_CENTRE = 0x70 and GAS_IDLE = 0x01;
- the 8-bit axis typedef.
REQ-027 A sub-module slew_limiter (8-bit current, target, up step, down step -> next) SHALL be instantiated once per axis.
- Combinational core, used in SLEW.

Verification
REQ-028 Reset release, X=0, Y=0, one vsync edge -> upd 4 cycles after tick; steering=0x70, gas=0x01.
REQ-029 X=+0x40 held for 5 frames -> target 0x90; steering 0x74, 0x78, 0x7C, 0x80, 0x84; X=+0x05 (deadzone) then slews back toward 0x70.
REQ-030 Y=-128 held -> gas 0x09, 0x11, ... clamps at 0xFF and never wraps; Y=0 -> falls by 16 per frame to 0x01.
REQ-031 Two vsync edges 2 cycles apart -> exactly two upd pulses, the second 4 cycles after the first COMMIT+1.
REQ-032 Reset pulsed during SLEW -> no upd; steering=0x70, gas=0x01; normal update on the next vsync.
